// File: rtl/ram_arbiter.sv
// Two-port arbiter and access sequencer for an asynchronous 32Kx8 SRAM.
// Define RAM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
`default_nettype none

module ram_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int WR_PULSE = 2,
    parameter int RD_WAIT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    inout  wire  [DATA_W-1:0] mem_data
);

    localparam int CNT_MAX = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WPULSE,
        S_WHOLD,
        S_RWAIT,
        S_DONE
    } state_t;

    state_t              state_q;
    logic                gnt_q;
    logic                wr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_write_q;
    logic                drive_q;
    logic                busy_q;
    logic                done0_q;
    logic                done1_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;

    // Grant decision for the request presented in IDLE (1 = port 1).
    logic                any_valid;
    logic                gnt_d;
    logic                wr_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;

    assign any_valid = req0_valid | req1_valid;

`ifdef RAM_ARB_RR_EN
    logic last_q;

    always_comb begin
        if (req0_valid && req1_valid) gnt_d = ~last_q;
        else                          gnt_d = ~req0_valid;
    end

    // Reset value 1 makes port 0 win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            last_q <= 1'b1;
        else if (state_q == S_IDLE && any_valid) last_q <= gnt_d;
    end
`else
    assign gnt_d = ~req0_valid;
`endif

    assign wr_d    = gnt_d ? req1_write : req0_write;
    assign addr_d  = gnt_d ? req1_addr  : req0_addr;
    assign wdata_d = gnt_d ? req1_wdata : req0_wdata;

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the asynchronous reset raises the strobe and releases the bus immediately.
            state_q     <= S_IDLE;
            gnt_q       <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_write_q <= 1'b1;
            drive_q     <= 1'b0;
            busy_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_valid) begin
                        state_q    <= S_SETUP;
                        gnt_q      <= gnt_d;
                        wr_q       <= wr_d;
                        mem_addr_q <= addr_d;
                        wdata_q    <= wdata_d;
                        drive_q    <= wr_d;
                        busy_q     <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (wr_q) begin
                        state_q     <= S_WPULSE;
                        mem_write_q <= 1'b0;
                        cnt_q       <= CNT_W'(WR_PULSE - 1);
                    end else begin
                        state_q <= S_RWAIT;
                        cnt_q   <= CNT_W'(RD_WAIT - 1);
                    end
                end
                S_WPULSE: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_WHOLD;
                        mem_write_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_WHOLD: begin
                    state_q <= S_DONE;
                    drive_q <= 1'b0;
                    done0_q <= ~gnt_q;
                    done1_q <= gnt_q;
                end
                S_RWAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_DONE;
                        done0_q <= ~gnt_q;
                        done1_q <= gnt_q;
                        if (gnt_q) rdata1_q <= mem_data;
                        else       rdata0_q <= mem_data;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req0_done  = done0_q;
    assign req1_done  = done1_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;
    assign busy       = busy_q;
    assign mem_addr   = mem_addr_q;
    assign mem_write  = mem_write_q;
    assign mem_data   = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule

`default_nettype wire
